gpu_frame_checker: RTL

Synthesizable on-chip successor to the frame-compare bench: it checks the GPU's video output in hardware rather than pixel-by-pixel in simulation. It taps the GPU pixel stream (pixel, x/y, drawing-valid, vsync) and accumulates a parametrised CRC per frame over a programmable rectangular window. Each frame's signature is latched and compared against an expected value, with sticky mismatch and failure counts, over N frames or continuously. Used for silicon self-test and regression without golden PNGs.

---
 rtl/gpu_frame_checker.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/gpu_frame_checker.sv
// In-line video signature checker: hashes the pixels that fall inside a window into a CRC
// for each frame, latches the result at vsync fall and compares it with a golden value.
module gpu_frame_checker #(
  parameter int                 PIXEL_W  = 6,
  parameter int                 X_W      = 8,
  parameter int                 Y_W      = 8,
  parameter int                 CRC_W    = 16,
  parameter logic [CRC_W-1:0]   CRC_POLY = 16'h1021,
  parameter logic [CRC_W-1:0]   CRC_INIT = {CRC_W{1'b1}},
  parameter int                 CNT_W    = 8
) (
  input  logic                 gpu_clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 pixel_valid_i,
  input  logic [PIXEL_W-1:0]   pixel_i,
  input  logic [X_W-1:0]       x_i,
  input  logic [Y_W-1:0]       y_i,
  input  logic                 vsync_i,
  input  logic [X_W-1:0]       win_x0_i,
  input  logic [X_W-1:0]       win_x1_i,
  input  logic [Y_W-1:0]       win_y0_i,
  input  logic [Y_W-1:0]       win_y1_i,
  input  logic [CRC_W-1:0]     expected_crc_i,
  input  logic                 compare_en_i,
  input  logic [CNT_W-1:0]     num_frames_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CRC_W-1:0]     crc_o,
  output logic                 crc_valid_o,
  output logic [X_W+Y_W-1:0]   pixel_count_o,
  output logic [CNT_W-1:0]     frames_checked_o,
  output logic [CNT_W-1:0]     fail_count_o,
  output logic                 mismatch_o
);

  localparam int PC_W = X_W + Y_W;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_vs_prev;
  logic [CRC_W-1:0]   r_acc;
  logic [PC_W-1:0]    r_pix_cnt;
  logic [CRC_W-1:0]   r_crc;
  logic               r_crc_valid;
  logic [PC_W-1:0]    r_pix_cnt_out;
  logic [CNT_W-1:0]   r_frames;
  logic [CNT_W-1:0]   r_fails;
  logic               r_mismatch;

  logic               w_vs_fall;
  logic               w_in_x;
  logic               w_in_y;
  logic               w_hit;
  logic [CRC_W-1:0]   w_crc_step;
  logic [CRC_W-1:0]   w_acc_final;
  logic [PC_W-1:0]    w_cnt_final;
  logic [CNT_W-1:0]   w_frames_next;
  logic               w_frame_fail;
  logic [CNT_W-1:0]   w_fails_next;
  logic               w_last_frame;

  // Whole pixel folded in one cycle, MSB first, non-reflected, no xor-out.
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] acc,
                                                input logic [PIXEL_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = acc;
    for (int b = PIXEL_W - 1; b >= 0; b--) begin
      fb = c[CRC_W-1] ^ data[b];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
    end
    return c;
  endfunction

  assign w_vs_fall = r_vs_prev & ~vsync_i;
  assign w_in_x    = (x_i >= win_x0_i) && (x_i <= win_x1_i);
  assign w_in_y    = (y_i >= win_y0_i) && (y_i <= win_y1_i);
  assign w_hit     = pixel_valid_i & w_in_x & w_in_y;

  assign w_crc_step  = crc_fold(r_acc, pixel_i);
  assign w_acc_final = w_hit ? w_crc_step : r_acc;
  assign w_cnt_final = (w_hit && (r_pix_cnt != {PC_W{1'b1}})) ? r_pix_cnt + 1'b1 : r_pix_cnt;

  // Frame-end bookkeeping uses the accumulator including a hit on the vsync-fall cycle.
  assign w_frames_next = r_frames + 1'b1;
  assign w_frame_fail  = compare_en_i && (w_acc_final != expected_crc_i);
  assign w_fails_next  = (w_frame_fail && (r_fails != {CNT_W{1'b1}})) ? r_fails + 1'b1 : r_fails;
  assign w_last_frame  = (num_frames_i != {CNT_W{1'b0}}) && (w_frames_next == num_frames_i);

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_vs_prev     <= 1'b1;
      r_acc         <= CRC_INIT;
      r_pix_cnt     <= '0;
      r_crc         <= '0;
      r_crc_valid   <= 1'b0;
      r_pix_cnt_out <= '0;
      r_frames      <= '0;
      r_fails       <= '0;
      r_mismatch    <= 1'b0;
    end else begin
      r_vs_prev   <= vsync_i;
      r_crc_valid <= 1'b0;
      if (abort_i) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              r_state    <= S_ARM;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_frames   <= '0;
              r_fails    <= '0;
              r_mismatch <= 1'b0;
              r_acc      <= CRC_INIT;
              r_pix_cnt  <= '0;
            end
          end
          S_ARM: begin
            // Pixels before the first frame boundary are partial; discard them.
            r_acc     <= CRC_INIT;
            r_pix_cnt <= '0;
            if (w_vs_fall) begin
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_vs_fall) begin
              r_crc         <= w_acc_final;
              r_pix_cnt_out <= w_cnt_final;
              r_crc_valid   <= 1'b1;
              r_frames      <= w_frames_next;
              r_fails       <= w_fails_next;
              if (w_frame_fail) begin
                r_mismatch <= 1'b1;
              end
              r_acc     <= CRC_INIT;
              r_pix_cnt <= '0;
              if (w_last_frame) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_acc     <= w_acc_final;
              r_pix_cnt <= w_cnt_final;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign crc_o            = r_crc;
  assign crc_valid_o      = r_crc_valid;
  assign pixel_count_o    = r_pix_cnt_out;
  assign frames_checked_o = r_frames;
  assign fail_count_o     = r_fails;
  assign mismatch_o       = r_mismatch;

endmodule
